// File: rtl/bus_demux_6502.sv
// Board-side demultiplexer for the time-multiplexed 6502 tile output stream.
// Rebuilds address/RW/SYNC, mirrors phi and issues one req/ack memory transaction per CPU cycle.
module bus_demux_6502 #(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned BUS_WIDTH     = 8,
  parameter bit          USE_FRAME     = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BUS_WIDTH-1:0]     bus_in,
  input  logic                     frame_in,
  input  logic [BUS_WIDTH-1:0]     cpu_data_in,
  output logic [BUS_WIDTH-1:0]     cpu_data_out,
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic                     rw,
  output logic                     sync,
  output logic                     frame_valid,
  output logic                     phi,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0]     mem_wdata,
  input  logic                     mem_ack,
  input  logic [BUS_WIDTH-1:0]     mem_rdata,
  output logic                     overrun
);

  typedef enum logic [1:0] {
    PH_LO  = 2'd0,
    PH_HI  = 2'd1,
    PH_CTL = 2'd2,
    PH_BAD = 2'd3
  } phase_t;

  phase_t               state_q;
  phase_t               state_d;
  logic [BUS_WIDTH-1:0] lo_q;
  logic [BUS_WIDTH-1:0] hi_q;

  logic realign_c;
  logic take_lo_c;
  logic take_hi_c;
  logic complete_c;
  logic issue_c;
  logic ack_c;
  logic start_c;

  // A frame marker outside the LO slot restarts the frame on this byte.
  assign realign_c  = USE_FRAME && frame_in && (state_q != PH_LO);
  assign take_lo_c  = (state_q == PH_LO) || realign_c;
  assign take_hi_c  = (state_q == PH_HI) && !realign_c;
  assign complete_c = (state_q == PH_CTL) && !realign_c;
  assign issue_c    = complete_c && !phi;
  assign ack_c      = mem_req && mem_ack;
  assign start_c    = issue_c && (!mem_req || mem_ack);

  // Phase state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PH_LO;
    end else begin
      state_q <= state_d;
    end
  end

  // Phase sequencing LO -> HI -> CTL -> LO
  always_comb begin
    state_d = PH_LO;
    if (realign_c) begin
      state_d = PH_HI;
    end else begin
      case (state_q)
        PH_LO:   state_d = PH_HI;
        PH_HI:   state_d = PH_CTL;
        default: state_d = PH_LO;
      endcase
    end
  end

  // Address byte holding registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      if (take_lo_c) lo_q <= bus_in;
      if (take_hi_c) hi_q <= bus_in;
    end
  end

  // Decoded frame outputs, phi mirror and completion strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr        <= '0;
      rw          <= 1'b1;
      sync        <= 1'b0;
      phi         <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= complete_c;
      if (complete_c) begin
        addr <= ADDRESS_WIDTH'({hi_q, lo_q});
        rw   <= bus_in[0];
        sync <= bus_in[1];
        phi  <= ~phi;
      end
    end
  end

  // Memory transaction: issue on phi rising, hold until acked, drop new request if still busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      overrun   <= 1'b0;
    end else begin
      if (start_c) begin
        mem_req   <= 1'b1;
        mem_we    <= ~bus_in[0];
        mem_addr  <= ADDRESS_WIDTH'({hi_q, lo_q});
        mem_wdata <= cpu_data_in;
      end else if (ack_c) begin
        mem_req   <= 1'b0;
      end
      if (issue_c && mem_req && !mem_ack) begin
        overrun <= 1'b1;
      end
    end
  end

  // Read data returned to the CPU; writes leave it untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_data_out <= '0;
    end else if (ack_c && !mem_we) begin
      cpu_data_out <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_bus_demux_6502.sv
// Self-checking bench for bus_demux_6502: queue-based frame model compared every cycle,
// plus directed literal checks on the key scenarios.
module tb_bus_demux_6502;

  logic        clk;
  logic        rst;
  logic [7:0]  bus_in;
  logic        frame_in;
  logic [7:0]  cpu_data_in;
  logic [7:0]  cpu_data_out;
  logic [15:0] addr;
  logic        rw;
  logic        sync;
  logic        frame_valid;
  logic        phi;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        overrun;

  int n_chk  = 0;
  int n_fail = 0;

  logic       auto_ack = 1'b1;
  logic [7:0] rd_val   = 8'h00;

  bus_demux_6502 #(
    .ADDRESS_WIDTH(16),
    .BUS_WIDTH    (8),
    .USE_FRAME    (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_in      (bus_in),
    .frame_in    (frame_in),
    .cpu_data_in (cpu_data_in),
    .cpu_data_out(cpu_data_out),
    .addr        (addr),
    .rw          (rw),
    .sync        (sync),
    .frame_valid (frame_valid),
    .phi         (phi),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: bytes collect into a frame queue; three bytes make a frame.
  logic [7:0]  fb[$];
  logic [7:0]  m_ctl;
  logic [15:0] m_addr = 16'h0, m_maddr = 16'h0;
  logic        m_rw = 1'b1, m_sync = 1'b0, m_phi = 1'b0, m_fv = 1'b0;
  logic        m_req = 1'b0, m_we = 1'b0, m_ovr = 1'b0;
  logic [7:0]  m_wdata = 8'h0, m_dout = 8'h0;
  logic        m_acked, m_done, m_rising;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fb.delete();
      m_addr = 16'h0; m_rw = 1'b1; m_sync = 1'b0; m_phi = 1'b0; m_fv = 1'b0;
      m_req = 1'b0; m_we = 1'b0; m_maddr = 16'h0; m_wdata = 8'h0; m_dout = 8'h0;
      m_ovr = 1'b0;
    end else begin
      m_acked  = m_req && mem_ack;
      m_done   = 1'b0;
      m_rising = 1'b0;
      m_fv     = 1'b0;
      if (frame_in && fb.size() != 0) fb.delete();
      fb.push_back(bus_in);
      if (fb.size() == 3) begin
        m_ctl    = fb[2];
        m_addr   = {fb[1], fb[0]};
        m_rw     = m_ctl[0];
        m_sync   = m_ctl[1];
        m_rising = !m_phi;
        m_phi    = !m_phi;
        m_fv     = 1'b1;
        m_done   = 1'b1;
        fb.delete();
      end
      if (m_acked && !m_we) m_dout = mem_rdata;
      if (m_done && m_rising) begin
        if (!m_req || m_acked) begin
          m_req   = 1'b1;
          m_maddr = m_addr;
          m_we    = !m_rw;
          m_wdata = cpu_data_in;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_acked) begin
        m_req = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("addr", addr, m_addr);
      chk("rw", rw, m_rw);
      chk("sync", sync, m_sync);
      chk("frame_valid", frame_valid, m_fv);
      chk("phi", phi, m_phi);
      chk("mem_req", mem_req, m_req);
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_maddr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("cpu_data_out", cpu_data_out, m_dout);
      chk("overrun", overrun, m_ovr);
    end
  end

  task automatic cyc(input logic [7:0] b, input logic fr = 1'b0,
                     input logic [7:0] din = 8'h00, input logic ack = 1'b0);
    @(negedge clk);
    bus_in      = b;
    frame_in    = fr;
    cpu_data_in = din;
    mem_rdata   = rd_val;
    mem_ack     = auto_ack ? (mem_req && !mem_ack) : ack;
    @(posedge clk);
    #2;
  endtask

  task automatic frame(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] ctl,
                       input logic [7:0] din = 8'h00, input logic fr = 1'b0);
    cyc(lo, fr, 8'h00);
    cyc(hi, 1'b0, 8'h00);
    cyc(ctl, 1'b0, din);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_addr"}, addr, 16'h0000);
    chk({tag, "_rw"}, rw, 1'b1);
    chk({tag, "_phi"}, phi, 1'b0);
    chk({tag, "_fv"}, frame_valid, 1'b0);
    chk({tag, "_req"}, mem_req, 1'b0);
    chk({tag, "_maddr"}, mem_addr, 16'h0000);
    chk({tag, "_dout"}, cpu_data_out, 8'h00);
    chk({tag, "_ovr"}, overrun, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus_in = 8'h00; frame_in = 1'b0; cpu_data_in = 8'h00;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    chk_reset_state("rst0");
    rst = 1'b0;

    // Frame A: read 0x1234, first frame_valid three cycles after LO
    rd_val = 8'hA9;
    cyc(8'h34);
    cyc(8'h12);
    chk("A_fv_early", frame_valid, 1'b0);
    cyc(8'h01);
    chk("A_fv", frame_valid, 1'b1);
    chk("A_addr", addr, 16'h1234);
    chk("A_rw", rw, 1'b1);
    chk("A_sync", sync, 1'b0);
    chk("A_phi", phi, 1'b1);
    chk("A_req", mem_req, 1'b1);
    chk("A_we", mem_we, 1'b0);
    chk("A_maddr", mem_addr, 16'h1234);
    // Frame B: phi falls, no new request; ack returns read data
    cyc(8'h34);
    chk("B_req_drop", mem_req, 1'b0);
    chk("B_dout", cpu_data_out, 8'hA9);
    cyc(8'h12);
    cyc(8'h01);
    chk("B_phi", phi, 1'b0);
    chk("B_req", mem_req, 1'b0);

    // Frame C: write 0x55 to 0x0200; read data must stay
    rd_val = 8'h77;
    frame(8'h00, 8'h02, 8'h00, 8'h55, 1'b1);
    chk("C_we", mem_we, 1'b1);
    chk("C_wdata", mem_wdata, 8'h55);
    chk("C_maddr", mem_addr, 16'h0200);
    cyc(8'h00);
    chk("C_req_drop", mem_req, 1'b0);
    chk("C_dout_kept", cpu_data_out, 8'hA9);
    // Frame D: control byte 0xFE -> rw=0, sync=1
    cyc(8'h03);
    cyc(8'hFE);
    chk("D_rw", rw, 1'b0);
    chk("D_sync", sync, 1'b1);
    chk("D_addr", addr, 16'h0300);

    // Frame E: realign during phase 2, then full frame from that byte
    rd_val = 8'h5A;
    cyc(8'h11);
    cyc(8'h22);
    cyc(8'h99, 1'b1);
    chk("E_no_fv", frame_valid, 1'b0);
    chk("E_phi_held", phi, 1'b0);
    cyc(8'hAA);
    cyc(8'h01);
    chk("E_fv", frame_valid, 1'b1);
    chk("E_addr", addr, 16'hAA99);
    chk("E_req", mem_req, 1'b1);
    frame(8'h00, 8'h40, 8'h03);
    chk("E2_dout", cpu_data_out, 8'h5A);

    // Simultaneous ack + completion, then overrun
    auto_ack = 1'b0;
    frame(8'h00, 8'h50, 8'h01);
    chk("F_maddr", mem_addr, 16'h5000);
    frame(8'h00, 8'h60, 8'h01);
    rd_val = 8'hC3;
    cyc(8'h00);
    cyc(8'h70);
    cyc(8'h00, 1'b0, 8'h66, 1'b1);
    chk("H_req", mem_req, 1'b1);
    chk("H_maddr", mem_addr, 16'h7000);
    chk("H_we", mem_we, 1'b1);
    chk("H_ovr", overrun, 1'b0);
    chk("H_dout", cpu_data_out, 8'hC3);
    frame(8'h00, 8'h71, 8'h01);
    frame(8'h00, 8'h72, 8'h01, 8'hEE);
    chk("J_ovr", overrun, 1'b1);
    chk("J_maddr", mem_addr, 16'h7000);
    chk("J_wdata", mem_wdata, 8'h66);
    chk("J_req", mem_req, 1'b1);

    // Frame K: ack the write, realign during phase 1
    cyc(8'h12, 1'b1, 8'h00, 1'b1);
    chk("K_req_drop", mem_req, 1'b0);
    chk("K_dout_kept", cpu_data_out, 8'hC3);
    auto_ack = 1'b1;
    cyc(8'hEE, 1'b1);
    cyc(8'hBE);
    cyc(8'h01);
    chk("K_addr", addr, 16'hBEEE);
    chk("K_phi", phi, 1'b0);
    chk("K_ovr", overrun, 1'b1);

    // Frame L: async reset while request pending
    frame(8'h00, 8'h80, 8'h01);
    chk("L_req", mem_req, 1'b1);
    rst = 1'b1;
    #1;
    chk_reset_state("rst1");
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Frame M: clean restart after reset
    frame(8'h34, 8'h12, 8'h01);
    chk("M_addr", addr, 16'h1234);
    chk("M_phi", phi, 1'b1);
    chk("M_req", mem_req, 1'b1);
    cyc(8'h00);
    cyc(8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
